relu_unit: RTL and testbench
============================

// Module: relu_unit
// PURPOSE
//  Registered ReLU activation for IEEE-754 floating-point words (default
//  binary32) in the CNN datapath of the food classifier. Passes non-negative
//  values unchanged and clamps negative values and NaNs to +0.0.
//  Sits after each conv/FC accumulator stage and before pooling.
// PARAMETERS
//  data_width  32  word width; sign = MSB, exponent = EXP_W bits below it
//  EXP_W       8   exponent field width (binary32 = 8; binary16 = 5)
//  MAN_W       data_width-1-EXP_W  mantissa field width (localparam, derived)
// PORTS
//  clk       in   1           clock; all state updates on rising edge
//  rst       in   1           asynchronous, active-high reset
//  data_in   in   data_width  signed float bit pattern to rectify
//  out_ReLU  out  data_width  rectified result, registered
// BEHAVIOUR
//  - Reset: while rst=1, out_ReLU = 0 immediately (async); no clock needed.
//  - Latency: exactly 1 cycle. data_in sampled on a rising edge appears on
//    out_ReLU after that edge. No enable/handshake: samples every edge.
//  - Fields: s = data_in[data_width-1], e = next EXP_W bits, m = low MAN_W bits.
//  - Decision, per sampled word:
//      NaN (e all ones, m != 0), either sign  -> out = 0 (+0.0)
//      s = 1 (negative normal/subnormal, -0.0, -inf) -> out = 0
//      s = 0 (+0.0, subnormal, normal, +inf) -> out = data_in, bit-exact
//  - -0.0 (only the MSB set) -> +0.0; the output never has the MSB set.
//  - Subnormals pass bit-exact; no flush-to-zero, no rounding, no arithmetic.
//  - Purely combinational decision feeding one data_width-bit register.
//  - rst asserted mid-stream: output clears at once; the first edge after
//    deassertion registers the current data_in normally.
//  - X/Z on data_in is not sanitized; the register captures it as-is.
// TESTING
//  1 rst=1, clk toggling -> out_ReLU=0x00000000; deassert -> normal operation.
//  2 data_in=0xC1266666 (-10.4) -> after next rising edge out_ReLU=0x00000000.
//  3 data_in=0x40B33333 (5.6) -> after next rising edge out_ReLU=0x40B33333.
//  4 data_in=0x00000002 (+subnormal) -> out_ReLU=0x00000002, bit-exact.
//  5 data_in=0x80000000 -> 0x00000000; 0x7F800000 -> 0x7F800000;
//    0xFF800000 -> 0x00000000; 0x7FC00000 and 0xFFC00001 -> 0x00000000.
//  6 Back-to-back changes every cycle: output equals the rectified input of
//    the previous edge; rst pulse between edges clears out_ReLU asynchronously.

Source files
------------

// File: rtl/relu_unit.sv
// relu_unit: one-cycle registered ReLU for IEEE-754 bit patterns.
// Non-negative values (including +inf and subnormals) pass bit-exact;
// negative values, -0.0, -inf and NaNs of either sign become +0.0.
module relu_unit #(
  parameter int data_width = 32,
  parameter int EXP_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] data_in,
  output logic [data_width-1:0] out_ReLU
);

  localparam int MAN_W = data_width - 1 - EXP_W;

  logic                  w_sign;
  logic [EXP_W-1:0]      w_exp;
  logic [MAN_W-1:0]      w_man;
  logic                  w_exp_ones;
  logic                  w_man_nz;
  logic                  w_is_nan;
  logic                  w_pass;
  logic [data_width-1:0] w_next;
  logic [data_width-1:0] r_out;

  assign w_sign = data_in[data_width-1];
  assign w_exp  = data_in[data_width-2 -: EXP_W];
  assign w_man  = data_in[MAN_W-1:0];

  // Field classification and pass/clamp decision on the incoming word.
  always_comb begin
    w_exp_ones = &w_exp;
    w_man_nz   = |w_man;
    w_is_nan   = w_exp_ones & w_man_nz;
    // A positive-signed NaN must still clamp, so NaN is checked independently of sign.
    w_pass     = ~w_sign & ~w_is_nan;
    w_next     = w_pass ? data_in : '0;
  end

  // Output register; reset clears it immediately without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_next;
    end
  end

  assign out_ReLU = r_out;

endmodule

// File: tb/tb_relu_unit.sv
// tb_relu_unit: directed and randomized checks of relu_unit (binary32).
module tb_relu_unit;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic [31:0] out_ReLU;

  int n_tests = 0;
  int n_fail  = 0;

  relu_unit #(.data_width(32), .EXP_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .out_ReLU (out_ReLU)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: classify the float by value ranges of its bit pattern.
  function automatic logic [31:0] relu_ref(input logic [31:0] x);
    longint unsigned v;
    longint unsigned expo;
    longint unsigned mant;
    bit              negative;
    bit              nan;
    v        = longint'(x);
    negative = (v >= 64'h8000_0000);
    expo     = (v / (64'd1 << 23)) % 64'd256;
    mant     = v % (64'd1 << 23);
    nan      = (expo == 64'd255) && (mant != 64'd0);
    if (nan || negative) return 32'h0000_0000;
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] exp_v);
    n_tests++;
    assert (out_ReLU === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, out_ReLU, exp_v);
    end
  endtask

  // Drive a word away from the edge, then check one cycle later.
  task automatic step(input string tag, input logic [31:0] d);
    @(negedge clk);
    data_in = d;
    @(posedge clk);
    #1;
    check(tag, relu_ref(d));
  endtask

  logic [31:0] rnd;
  logic [31:0] prev;

  initial begin
    rst     = 1'b1;
    data_in = 32'hC126_6666;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;

    step("neg_10p4",     32'hC126_6666);
    step("pos_5p6",      32'h40B3_3333);
    step("pos_subnorm",  32'h0000_0002);
    step("neg_zero",     32'h8000_0000);
    step("pos_inf",      32'h7F80_0000);
    step("neg_inf",      32'hFF80_0000);
    step("qnan_pos",     32'h7FC0_0000);
    step("nan_neg",      32'hFFC0_0001);
    step("snan_pos_min", 32'h7F80_0001);
    step("pos_zero",     32'h0000_0000);
    step("max_normal",   32'h7F7F_FFFF);
    step("neg_subnorm",  32'h8000_0001);

    // Constants at the 1-cycle latency: value must not appear before the edge.
    @(negedge clk);
    prev    = out_ReLU;
    data_in = 32'h3F80_0000;
    #1;
    check("latency_hold", relu_ref(32'h8000_0001));
    @(posedge clk);
    #1;
    check("latency_edge", 32'h3F80_0000);

    // Randomized back-to-back words, biased toward the inf/NaN exponent.
    for (int i = 0; i < 300; i++) begin
      rnd = $urandom();
      if ((i % 4) == 0) rnd[30:23] = 8'hFF;
      if ((i % 16) == 1) rnd[22:0] = '0;
      step("random", rnd);
    end

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    data_in = 32'h4000_0000;
    @(posedge clk);
    #1;
    check("pre_rst", 32'h4000_0000);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 32'h0000_0000);
    @(negedge clk);
    rst     = 1'b0;
    data_in = 32'h4120_0000;
    @(posedge clk);
    #1;
    check("post_rst_first", 32'h4120_0000);
    step("post_rst_neg", 32'hBF80_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
